// File: rtl/adc_trig_pkg.sv
// Shared types and helpers for the ADC trigger unit: FSM state encoding,
// slope selection constants and saturating threshold arithmetic.
package adc_trig_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRIMED  = 2'd1,
        ARMED   = 2'd2,
        HOLDOFF = 2'd3
    } trig_state_e;

    localparam logic SLOPE_RISE = 1'b0;
    localparam logic SLOPE_FALL = 1'b1;

    // Working width for threshold math; sample widths up to 31 bits fit.
    localparam int SAT_W = 32;

    function automatic logic [SAT_W-1:0] sat_add(
        input logic [SAT_W-1:0] a,
        input logic [SAT_W-1:0] b,
        input logic [SAT_W-1:0] max_val
    );
        logic [SAT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, max_val}) ? max_val : sum[SAT_W-1:0];
    endfunction

    function automatic logic [SAT_W-1:0] sat_sub(
        input logic [SAT_W-1:0] a,
        input logic [SAT_W-1:0] b
    );
        return (a > b) ? (a - b) : '0;
    endfunction

endpackage

// File: rtl/adc_trig_counter.sv
// Saturating up-counter shared by the holdoff and auto-trigger timers.
// Clear has priority over enable; the count sticks at all-ones.
module adc_trig_counter
    import adc_trig_pkg::*;
#(
    parameter int W = 24
) (
    input  logic         clk_adc,
    input  logic         reset,
    input  logic         clear_i,
    input  logic         enable_i,
    output logic [W-1:0] count_o,
    output logic         sat_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    assign sat_o   = &count_q;
    assign count_o = count_q;

    always_comb begin
        // NOTE: default assignment first so no path leaves count_d unassigned (no latch).
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && !sat_o) begin
            count_d = count_q + W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk_adc) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/adc_trigger_unit.sv
// ADC front-end: two-stage sample pipeline plus a hysteresis/slope trigger FSM
// with holdoff and auto-trigger; trig is aligned with the adc_out sample.
module adc_trigger_unit
    import adc_trig_pkg::*;
#(
    parameter int DW        = 14,
    parameter int HOLDOFF_W = 16,
    parameter int AUTO_W    = 24
) (
    input  logic                 clk_adc,
    input  logic                 reset,
    input  logic [DW-1:0]        adc_in,
    input  logic                 arm,
    input  logic [DW-1:0]        level,
    input  logic [DW-1:0]        hyst,
    input  logic                 slope,
    input  logic [HOLDOFF_W-1:0] holdoff,
    input  logic                 auto_en,
    input  logic [AUTO_W-1:0]    auto_timeout,
    output logic [DW-1:0]        adc_out,
    output logic                 trig,
    output logic                 trig_auto,
    output logic [1:0]           state
);

    localparam logic [SAT_W-1:0] SAMPLE_MAX = SAT_W'({DW{1'b1}});

    logic [DW-1:0]   s1_q;
    logic [DW-1:0]   adc_out_q;
    logic            trig_q, trig_d;
    logic            trig_auto_q, trig_auto_d;
    trig_state_e     state_q, state_d;

    logic [DW-1:0]        lo, hi;
    logic [HOLDOFF_W-1:0] hold_m1;
    logic [AUTO_W-1:0]    cnt;
    logic                 cnt_sat;
    logic                 cnt_clr;
    logic                 cnt_en;
    logic                 rearm_hit;
    logic                 level_hit;
    logic                 auto_hit;
    logic                 hold_done;

    assign lo = DW'(sat_sub(SAT_W'(level), SAT_W'(hyst)));
    assign hi = DW'(sat_add(SAT_W'(level), SAT_W'(hyst), SAMPLE_MAX));

    assign rearm_hit = (slope == SLOPE_FALL) ? (s1_q > hi) : (s1_q < lo);
    assign level_hit = (slope == SLOPE_RISE) ? (s1_q >= level) : (s1_q <= level);

    // auto_timeout=0 wraps to all-ones, which the saturated counter is excluded from.
    assign auto_hit = auto_en && !cnt_sat && (cnt == auto_timeout - AUTO_W'(1));

    assign hold_m1   = (holdoff == '0) ? '0 : holdoff - HOLDOFF_W'(1);
    assign hold_done = (cnt >= AUTO_W'(hold_m1));

    adc_trig_counter #(
        .W (AUTO_W)
    ) u_counter (
        .clk_adc  (clk_adc),
        .reset    (reset),
        .clear_i  (cnt_clr),
        .enable_i (cnt_en),
        .count_o  (cnt),
        .sat_o    (cnt_sat)
    );

    always_comb begin
        state_d     = state_q;
        trig_d      = 1'b0;
        trig_auto_d = 1'b0;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_clr = 1'b1;
                if (arm) begin
                    state_d = PRIMED;
                end
            end
            PRIMED, ARMED: begin
                cnt_en = 1'b1;
                // Disarm beats any trigger evaluated in the same cycle.
                if (!arm) begin
                    state_d = IDLE;
                    cnt_clr = 1'b1;
                end else if ((state_q == ARMED) && level_hit) begin
                    state_d = HOLDOFF;
                    trig_d  = 1'b1;
                    cnt_clr = 1'b1;
                end else if (auto_hit) begin
                    state_d     = HOLDOFF;
                    trig_d      = 1'b1;
                    trig_auto_d = 1'b1;
                    cnt_clr     = 1'b1;
                end else if ((state_q == PRIMED) && rearm_hit) begin
                    state_d = ARMED;
                end
            end
            HOLDOFF: begin
                cnt_en = 1'b1;
                if (hold_done) begin
                    cnt_clr = 1'b1;
                    state_d = arm ? PRIMED : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_clr = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_adc) begin
        if (reset) begin
            s1_q        <= '0;
            adc_out_q   <= '0;
            trig_q      <= 1'b0;
            trig_auto_q <= 1'b0;
            state_q     <= IDLE;
        end else begin
            s1_q        <= adc_in;
            adc_out_q   <= s1_q;
            trig_q      <= trig_d;
            trig_auto_q <= trig_auto_d;
            state_q     <= state_d;
        end
    end

    assign adc_out   = adc_out_q;
    assign trig      = trig_q;
    assign trig_auto = trig_auto_q;
    assign state     = state_q;

endmodule

// File: tb/tb_adc_trigger_unit.sv
// Scoreboard bench for adc_trigger_unit: each driven sample queues its expected
// adc_out/trig/trig_auto, popped when that sample emerges two cycles later.
module tb_adc_trigger_unit;
    import adc_trig_pkg::*;

    localparam int DW        = 14;
    localparam int HOLDOFF_W = 16;
    localparam int AUTO_W    = 24;

    logic                 clk_adc = 1'b0;
    logic                 reset;
    logic [DW-1:0]        adc_in;
    logic                 arm;
    logic [DW-1:0]        level;
    logic [DW-1:0]        hyst;
    logic                 slope;
    logic [HOLDOFF_W-1:0] holdoff;
    logic                 auto_en;
    logic [AUTO_W-1:0]    auto_timeout;
    logic [DW-1:0]        adc_out;
    logic                 trig;
    logic                 trig_auto;
    logic [1:0]           state;

    adc_trigger_unit #(
        .DW        (DW),
        .HOLDOFF_W (HOLDOFF_W),
        .AUTO_W    (AUTO_W)
    ) dut (
        .clk_adc      (clk_adc),
        .reset        (reset),
        .adc_in       (adc_in),
        .arm          (arm),
        .level        (level),
        .hyst         (hyst),
        .slope        (slope),
        .holdoff      (holdoff),
        .auto_en      (auto_en),
        .auto_timeout (auto_timeout),
        .adc_out      (adc_out),
        .trig         (trig),
        .trig_auto    (trig_auto),
        .state        (state)
    );

    always #5 clk_adc = ~clk_adc;

    typedef struct packed {
        logic [DW-1:0] sample;
        logic          trig;
        logic          trig_auto;
    } exp_t;

    exp_t exp_q[$];

    int tests_run       = 0;
    int tests_failed    = 0;
    int cyc             = 0;
    int last_trig_cyc   = -1000;
    int min_gap         = 1 << 30;
    int trig_seen       = 0;
    bit trig_in_holdoff = 1'b0;

    // One clock of stimulus; compares the entry whose sample reaches adc_out now.
    task automatic step(input logic [DW-1:0] s, input logic et, input logic ea);
        exp_t       e;
        logic [1:0] st_before;
        adc_in = s;
        exp_q.push_back(exp_t'{sample: s, trig: et, trig_auto: ea});
        st_before = state;
        @(posedge clk_adc);
        #1;
        cyc++;
        if (trig === 1'b1) begin
            if (st_before == HOLDOFF) trig_in_holdoff = 1'b1;
            if (cyc - last_trig_cyc < min_gap) min_gap = cyc - last_trig_cyc;
            last_trig_cyc = cyc;
            trig_seen++;
        end
        if (exp_q.size() >= 2) begin
            e = exp_q.pop_front();
            tests_run++;
            if (adc_out !== e.sample || trig !== e.trig || trig_auto !== e.trig_auto) begin
                tests_failed++;
                $display("FAIL stream@%0d: adc_out=%0d trig=%b trig_auto=%b, expected adc_out=%0d trig=%b trig_auto=%b",
                         cyc, adc_out, trig, trig_auto, e.sample, e.trig, e.trig_auto);
            end
        end
    endtask

    task automatic go_idle(input logic [DW-1:0] s);
        arm     = 1'b0;
        auto_en = 1'b0;
        repeat (14) step(s, 1'b0, 1'b0);
        tests_run++;
        if (state !== IDLE) begin
            tests_failed++;
            $display("FAIL go_idle_state: state=%0d, expected %0d", state, IDLE);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; arm = 1'b0; adc_in = 14'd5;
        level = '0; hyst = '0; slope = 1'b0; holdoff = '0;
        auto_en = 1'b0; auto_timeout = '0;
        repeat (3) @(posedge clk_adc);
        #1;
        tests_run++;
        if (adc_out !== '0 || trig !== 1'b0 || trig_auto !== 1'b0 || state !== IDLE) begin
            tests_failed++;
            $display("FAIL reset_values: adc_out=%0d trig=%b trig_auto=%b state=%0d, expected 0 0 0 0",
                     adc_out, trig, trig_auto, state);
        end
        reset = 1'b0;
        exp_q.delete();
        step(14'd0, 1'b0, 1'b0);
        tests_run++;
        if (adc_out !== '0) begin
            tests_failed++;
            $display("FAIL reset_s1_cleared: adc_out=%0d, expected 0", adc_out);
        end
    endtask

    task automatic test_idle_ramp();
        int fails_here;
        fails_here = 0;
        arm = 1'b0;
        for (int i = 0; i < 16384; i++) begin
            step(DW'(i), 1'b0, 1'b0);
            if (state !== IDLE) fails_here++;
        end
        tests_run++;
        if (fails_here != 0) begin
            tests_failed++;
            $display("FAIL idle_state: %0d cycles left IDLE, expected 0", fails_here);
        end
    endtask

    task automatic test_rising();
        int t0;
        level = 14'd8192; hyst = 14'd100; slope = SLOPE_RISE; holdoff = '0; auto_en = 1'b0;
        t0 = trig_seen;
        step(14'd8000, 1'b0, 1'b0);
        arm = 1'b1;
        step(14'd8150, 1'b0, 1'b0);
        step(14'd8192, 1'b0, 1'b0);
        tests_run++;
        if (state !== PRIMED) begin
            tests_failed++;
            $display("FAIL rise_not_armed: state=%0d, expected %0d", state, PRIMED);
        end
        step(14'd8000, 1'b0, 1'b0);
        step(14'd8050, 1'b0, 1'b0);
        tests_run++;
        if (state !== ARMED) begin
            tests_failed++;
            $display("FAIL rise_armed: state=%0d, expected %0d", state, ARMED);
        end
        step(14'd8192, 1'b1, 1'b0);
        step(14'd8192, 1'b0, 1'b0);
        tests_run++;
        if (state !== HOLDOFF) begin
            tests_failed++;
            $display("FAIL rise_holdoff: state=%0d, expected %0d", state, HOLDOFF);
        end
        repeat (6) step(14'd8192, 1'b0, 1'b0);
        tests_run++;
        if (trig_seen - t0 != 1) begin
            tests_failed++;
            $display("FAIL rise_count: %0d pulses, expected 1", trig_seen - t0);
        end
        go_idle(14'd8192);
    endtask

    task automatic test_falling();
        int t0;
        level = 14'd4000; hyst = 14'd50; slope = SLOPE_FALL; holdoff = '0;
        t0 = trig_seen;
        step(14'd4000, 1'b0, 1'b0);
        arm = 1'b1;
        step(14'd5000, 1'b0, 1'b0);
        step(14'd4051, 1'b0, 1'b0);
        tests_run++;
        if (state !== ARMED) begin
            tests_failed++;
            $display("FAIL fall_armed: state=%0d, expected %0d", state, ARMED);
        end
        step(14'd3000, 1'b1, 1'b0);
        repeat (7) step(14'd3000, 1'b0, 1'b0);
        tests_run++;
        if (trig_seen - t0 != 1) begin
            tests_failed++;
            $display("FAIL fall_count: %0d pulses, expected 1", trig_seen - t0);
        end
        go_idle(14'd3000);
    endtask

    task automatic test_holdoff();
        logic [DW-1:0] pat [4];
        int t0;
        pat[0] = 14'd6000; pat[1] = 14'd6000; pat[2] = 14'd10000; pat[3] = 14'd10000;
        level = 14'd8192; hyst = 14'd100; slope = SLOPE_RISE; holdoff = 16'd10;
        step(14'd6000, 1'b0, 1'b0);
        last_trig_cyc = -1000; min_gap = 1 << 30; trig_in_holdoff = 1'b0; t0 = trig_seen;
        arm = 1'b1;
        // A crossing every 4 cycles re-arms only after each 10-cycle holdoff: a pulse every 12.
        for (int j = 0; j < 50; j++) step(pat[j % 4], (j % 12) == 2, 1'b0);
        tests_run++;
        if (min_gap < 11 || trig_in_holdoff) begin
            tests_failed++;
            $display("FAIL holdoff_gap: min gap %0d, in_holdoff=%b, expected >=11 and 0", min_gap, trig_in_holdoff);
        end
        tests_run++;
        if (trig_seen - t0 != 4) begin
            tests_failed++;
            $display("FAIL holdoff_count: %0d pulses, expected 4", trig_seen - t0);
        end
        go_idle(14'd6000);
    endtask

    task automatic test_auto();
        int t0;
        level = 14'd8192; hyst = 14'd100; slope = SLOPE_RISE; holdoff = 16'd5;
        auto_en = 1'b1; auto_timeout = 24'd50;
        step(14'd100, 1'b0, 1'b0);
        last_trig_cyc = -1000; min_gap = 1 << 30; t0 = trig_seen;
        arm = 1'b1;
        for (int j = 0; j < 170; j++) begin
            step(14'd100, (j >= 49) && ((j - 49) % 55 == 0), (j >= 49) && ((j - 49) % 55 == 0));
            if (j == 0) begin
                tests_run++;
                if (state !== PRIMED) begin
                    tests_failed++;
                    $display("FAIL auto_primed: state=%0d, expected %0d", state, PRIMED);
                end
            end
        end
        tests_run++;
        if (trig_seen - t0 != 3 || min_gap != 55) begin
            tests_failed++;
            $display("FAIL auto_period: %0d pulses gap %0d, expected 3 gap 55", trig_seen - t0, min_gap);
        end
        go_idle(14'd100);
        auto_en = 1'b1; auto_timeout = '0; arm = 1'b1;
        repeat (80) step(14'd100, 1'b0, 1'b0);
        go_idle(14'd100);
    endtask

    task automatic test_priority();
        level = 14'd8192; hyst = 14'd100; slope = SLOPE_RISE; holdoff = '0;
        step(14'd6000, 1'b0, 1'b0);
        auto_en = 1'b1; auto_timeout = 24'd3; arm = 1'b1;
        step(14'd6000, 1'b0, 1'b0);
        step(14'd6000, 1'b0, 1'b0);
        step(14'd10000, 1'b1, 1'b0);
        step(14'd10000, 1'b0, 1'b0);
        step(14'd10000, 1'b0, 1'b0);
        step(14'd10000, 1'b0, 1'b0);
        step(14'd10000, 1'b1, 1'b1);
        step(14'd10000, 1'b0, 1'b0);
        go_idle(14'd10000);
    endtask

    task automatic test_abort();
        level = 14'd8192; hyst = 14'd100; slope = SLOPE_RISE; holdoff = '0; auto_en = 1'b0;
        step(14'd6000, 1'b0, 1'b0);
        arm = 1'b1;
        step(14'd6000, 1'b0, 1'b0);
        step(14'd10000, 1'b0, 1'b0);
        tests_run++;
        if (state !== ARMED) begin
            tests_failed++;
            $display("FAIL abort_armed: state=%0d, expected %0d", state, ARMED);
        end
        arm = 1'b0;
        step(14'd10000, 1'b0, 1'b0);
        tests_run++;
        if (state !== IDLE) begin
            tests_failed++;
            $display("FAIL abort_disarm: state=%0d, expected %0d", state, IDLE);
        end
        repeat (3) step(14'd10000, 1'b0, 1'b0);

        holdoff = 16'd10; arm = 1'b1;
        step(14'd6000, 1'b0, 1'b0);
        step(14'd10000, 1'b1, 1'b0);
        step(14'd10000, 1'b0, 1'b0);
        step(14'd10000, 1'b0, 1'b0);
        tests_run++;
        if (state !== HOLDOFF) begin
            tests_failed++;
            $display("FAIL abort_holdoff: state=%0d, expected %0d", state, HOLDOFF);
        end
        reset = 1'b1;
        @(posedge clk_adc);
        #1;
        tests_run++;
        if (adc_out !== '0 || trig !== 1'b0 || trig_auto !== 1'b0 || state !== IDLE) begin
            tests_failed++;
            $display("FAIL abort_reset: adc_out=%0d trig=%b trig_auto=%b state=%0d, expected 0 0 0 0",
                     adc_out, trig, trig_auto, state);
        end
        arm = 1'b0;
        @(posedge clk_adc);
        #1;
        reset = 1'b0;
        exp_q.delete();
        repeat (4) step(14'd10000, 1'b0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_idle_ramp();
        test_rising();
        test_falling();
        test_holdoff();
        test_auto();
        test_priority();
        test_abort();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/adc_trigger_unit.md
Name: adc_trigger_unit

Overview:
- Front-end stage on clk_adc, directly upstream of the RAM capture controller.
- Registers raw ADC samples and emits a one-cycle trigger pulse aligned with the registered sample stream. Trigger sources: level crossing with hysteresis, selectable slope, holdoff, and an optional auto-trigger timeout.
- The capture controller consumes adc_out and trig in place of its own internal threshold/edge detector.

Parameters:
DW, 14, ADC sample width (offset binary, unsigned)
HOLDOFF_W, 16, width of holdoff count
AUTO_W, 24, width of auto-trigger timeout count

Ports:
clk_adc  in  1  ADC sample clock
reset  in  1  synchronous, active-high
adc_in  in  DW  raw sample, one per clk_adc
arm  in  1  level; trigger search enabled while high
level  in  DW  trigger level
hyst  in  DW  hysteresis band
slope  in  1  0 = rising, 1 = falling
holdoff  in  HOLDOFF_W  cycles spent in HOLDOFF after a trigger
auto_en  in  1  enable auto-trigger
auto_timeout  in  AUTO_W  cycles without a trigger before a forced one
adc_out  out  DW  sample delayed exactly 2 cycles
trig  out  1  one-cycle trigger pulse
trig_auto  out  1  high with trig when the trigger was forced
state  out  2  FSM state (debug)

Behaviour:
- Reset: adc_out=0, trig=0, trig_auto=0, state=IDLE, counter=0, s1=0.
- Pipeline:
  - s1 <= adc_in.
  - adc_out <= s1.
  - trig and trig_auto are registered in the same edge as adc_out, so trig marks the adc_out sample that satisfied the condition.
  - Latency from adc_in to adc_out/trig is 2 cycles.
- Thresholds (combinational, unsigned):
  - lo = level - hyst, saturating at 0.
  - hi = level + hyst, saturating at 2^DW-1.
- Config inputs are quasi-static. A mid-operation change takes effect on the next compare with no glitch guarantee.
- FSM states:
  - IDLE=0, PRIMED=1, ARMED=2, HOLDOFF=3.
- Transitions:
  - IDLE -> PRIMED when arm=1. Counter cleared.
  - PRIMED -> ARMED:
    - rising: when s1 < lo.
    - falling: when s1 > hi.
  - ARMED -> HOLDOFF with trig=1:
    - rising: when s1 >= level.
    - falling: when s1 <= level.
  - PRIMED or ARMED -> HOLDOFF with trig=1 and trig_auto=1 when auto_en=1 and counter == auto_timeout-1.
    - Counter increments every cycle in PRIMED/ARMED and saturates.
    - auto_timeout=0 means the timeout is never reached.
  - Same-cycle priority: a level trigger wins over auto; trig_auto=0 in that case.
  - HOLDOFF lasts max(holdoff,1) cycles. Counter is cleared on entry.
    - Exit to PRIMED if arm=1, else IDLE.
    - Counter is cleared on exit.
  - arm=0 in PRIMED or ARMED -> IDLE next cycle. No trig is issued in that cycle.
  - arm=0 in HOLDOFF: the holdoff completes, then the FSM goes to IDLE.
- trig is never high on two consecutive cycles; at least max(holdoff,1)+1 cycles separate pulses.
- A reset mid-operation returns to reset values on the next edge. Any pending trigger is dropped.

Decomposition:
- Package adc_trig_pkg:
  - state enum {IDLE, PRIMED, ARMED, HOLDOFF}, 2 bits.
  - Saturating add/sub functions for lo/hi.
  - SLOPE_RISE=0 and SLOPE_FALL=1 constants.
- One sub-module, adc_trig_counter:
  - Shared up-counter, AUTO_W wide (holdoff zero-extended).
  - Inputs: clear, enable.
  - Outputs: count, saturation flag.
  - Reused for both the holdoff and auto-timeout functions.

Test Plan:
- Reset then idle: arm=0, adc_in ramp 0..16383 -> trig never asserted; adc_out equals adc_in delayed 2 cycles; state=0.
- Rising with hysteresis:
  - Setup: level=8192, hyst=100, slope=0, arm=1.
  - Stimulus: adc_in 8000 -> 8150 -> 8192.
  - Required: no trig, because the sample never fell below 8092.
  - Stimulus continues: 8000 -> 8050 -> 8192.
  - Required: exactly one trig, coinciding with adc_out=8192.
- Falling slope: slope=1, level=4000, hyst=50, samples 5000, 4051, 3000 -> one trig with adc_out=3000.
- Holdoff: holdoff=10, sine crossing the level every 4 cycles -> successive trig pulses are at least 11 cycles apart, and none occur inside HOLDOFF.
- Auto-trigger: auto_en=1, auto_timeout=50, adc_in constant 100, level=8192 -> trig=1 and trig_auto=1 exactly 50 cycles after entering PRIMED, then repeating every 50+max(holdoff,1) cycles.
- Abort:
  - Case 1: arm dropped while ARMED on the same cycle the crossing sample is in s1 -> no trig; state=IDLE.
  - Case 2: reset asserted in HOLDOFF -> all outputs 0 next cycle.
